// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if -- operand/result bus of the HI/LO multiply-divide unit.
//   A, B   : operands (rs, rt)            MDOp  : operation code
//   Start  : qualifies MDOp/A/B one cycle Busy  : multi-cycle op in flight
//   HI, LO : architectural result registers
// master = issuing pipeline, slave = mult_div_unit.
interface mult_div_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDOp, Start, input  Busy, HI, LO);
    modport slave  (input  A, B, MDOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- MIPS-style HI/LO multiply/divide unit.
// The result is computed combinationally at the Start edge and parked in a
// holding register; HI/LO only take it after the modelled latency, so the
// pipeline sees the architectural timing of an iterative unit.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : mult_div_unit_if.slave (A, B, MDOp, Start in; Busy, HI, LO out)
// Parameters: MULT_CYCLES (multiply latency), DIV_CYCLES (divide latency).
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// accumulate ops; otherwise those codes are no-ops.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic              clk,
    input logic              reset,
    mult_div_unit_if.slave   bus
);
    localparam int MAXL = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0110;
    localparam logic [3:0] OP_MADDU = 4'b0111;
    localparam logic [3:0] OP_MSUB  = 4'b1000;
    localparam logic [3:0] OP_MSUBU = 4'b1001;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]    r_hi, r_lo;
    logic [31:0]    r_res_hi, r_res_lo;
    logic           r_res_we;

    // Datapath: every candidate result, selected by MDOp
    logic signed [63:0] w_a_sx, w_b_sx, w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_as, w_bs, w_q_s, w_r_s;
    logic [31:0]        w_q_u, w_r_u;
    logic [63:0]        w_res;
    logic               w_we, w_run;
    logic [CW-1:0]      w_lat;

    assign w_a_sx   = {{32{bus.A[31]}}, bus.A};
    assign w_b_sx   = {{32{bus.B[31]}}, bus.B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign w_as     = bus.A;
    assign w_bs     = bus.B;

    always_comb begin
        w_q_s = '0;
        w_r_s = '0;
        w_q_u = '0;
        w_r_u = '0;
        // Guard divide-by-zero; the quotient is discarded in that case anyway
        if (bus.B != 32'd0) begin
            w_q_s = w_as / w_bs;
            w_r_s = w_as % w_bs;
            w_q_u = bus.A / bus.B;
            w_r_u = bus.A % bus.B;
        end
    end

    always_comb begin
        w_res = {r_hi, r_lo};
        w_we  = 1'b0;
        w_run = 1'b0;
        w_lat = '0;
        case (bus.MDOp)
            OP_MULT:  begin w_res = w_prod_s; w_we = 1'b1; w_run = 1'b1; w_lat = CW'(MULT_CYCLES); end
            OP_MULTU: begin w_res = w_prod_u; w_we = 1'b1; w_run = 1'b1; w_lat = CW'(MULT_CYCLES); end
            OP_DIV: begin
                w_run = 1'b1;
                w_lat = CW'(DIV_CYCLES);
                w_we  = (bus.B != 32'd0);
                // Most-negative / -1 overflows: pin the MIPS result explicitly
                if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF)
                    w_res = {32'd0, 32'h8000_0000};
                else
                    w_res = {w_r_s, w_q_s};
            end
            OP_DIVU: begin
                w_run = 1'b1;
                w_lat = CW'(DIV_CYCLES);
                w_we  = (bus.B != 32'd0);
                w_res = {w_r_u, w_q_u};
            end
`ifdef MDU_MADD_EN
            // Accumulate against HI/LO as they stand at the Start edge
            OP_MADD:  begin w_res = {r_hi, r_lo} + w_prod_s; w_we = 1'b1; w_run = 1'b1; w_lat = CW'(MULT_CYCLES); end
            OP_MADDU: begin w_res = {r_hi, r_lo} + w_prod_u; w_we = 1'b1; w_run = 1'b1; w_lat = CW'(MULT_CYCLES); end
            OP_MSUB:  begin w_res = {r_hi, r_lo} - w_prod_s; w_we = 1'b1; w_run = 1'b1; w_lat = CW'(MULT_CYCLES); end
            OP_MSUBU: begin w_res = {r_hi, r_lo} - w_prod_u; w_we = 1'b1; w_run = 1'b1; w_lat = CW'(MULT_CYCLES); end
`endif
            default: ;
        endcase
    end

    // FSM next-state / control
    logic w_cap, w_commit, w_mthi, w_mtlo;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    if (w_run) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = w_lat;
                        w_cap       = 1'b1;
                    end
                    w_mthi = (bus.MDOp == OP_MTHI);
                    w_mtlo = (bus.MDOp == OP_MTLO);
                end
            end
            RUN: begin
                // Counter holds L after edge N; the edge that sees 1 is N+L
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_we <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cap) begin
                r_res_hi <= w_res[63:32];
                r_res_lo <= w_res[31:0];
                r_res_we <= w_we;
            end
            if (w_commit && r_res_we) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
            if (w_mthi) r_hi <= bus.A;
            if (w_mtlo) r_lo <= bus.A;
        end
    end

    assign bus.Busy = (r_state == RUN);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule
